// File: rtl/i2c_bus_cond_det.sv
// I2C bus condition detector: deglitches synchronized SCL/SDA and emits single-cycle
// SCL edge, START, repeated START, STOP and SCL-low timeout pulses plus bus busy state.
module i2c_bus_cond_det #(
   parameter int FILT_LEN    = 3,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_sync,
   input  logic sda_sync,
   output logic scl_filt,
   output logic sda_filt,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic rstart_det,
   output logic stop_det,
   output logic timeout,
   output logic bus_busy
);

   localparam int            TW        = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [3:0]    FILT_LAST = 4'(FILT_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
   localparam logic [TW-1:0] TO_MAX    = '1;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_scl_cnt, r_sda_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_scl_filt, r_sda_filt, r_scl_d, r_sda_d;
   logic          r_scl_rise, r_scl_fall;
   logic          r_start, r_rstart, r_stop, r_timeout;
   logic          w_start_nxt, w_rstart_nxt, w_stop_nxt, w_timeout_nxt;
   logic          w_start_cond, w_stop_cond, w_to_hit;

   // Filtered line follows the input only after FILT_LEN consecutive differing edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
         r_scl_cnt  <= '0;
         r_sda_cnt  <= '0;
      end else begin
         if (scl_sync == r_scl_filt) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == FILT_LAST) begin
            r_scl_filt <= scl_sync;
            r_scl_cnt  <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + 4'd1;
         end
         if (sda_sync == r_sda_filt) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == FILT_LAST) begin
            r_sda_filt <= sda_sync;
            r_sda_cnt  <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + 4'd1;
         end
      end
   end

   // SCL must be high on both samples, so a simultaneous SCL/SDA change is never a condition.
   assign w_start_cond = r_sda_d & ~r_sda_filt & r_scl_d & r_scl_filt;
   assign w_stop_cond  = ~r_sda_d & r_sda_filt & r_scl_d & r_scl_filt;
   assign w_to_hit     = (TIMEOUT_CYC != 0) && (r_state == ST_BUSY) && !r_scl_filt
                         && (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt   = r_state;
      w_start_nxt   = 1'b0;
      w_rstart_nxt  = 1'b0;
      w_stop_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_cond) begin
               w_state_nxt = ST_BUSY;
               w_start_nxt = 1'b1;
            end else if (w_stop_cond) begin
               w_stop_nxt = 1'b1;
            end
         end
         ST_BUSY: begin
            if (w_stop_cond) begin
               w_state_nxt = ST_IDLE;
               w_stop_nxt  = 1'b1;
            end else if (w_start_cond) begin
               w_rstart_nxt = 1'b1;
            end else if (w_to_hit) begin
               w_state_nxt   = ST_IDLE;
               w_timeout_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_rstart   <= 1'b0;
         r_stop     <= 1'b0;
         r_timeout  <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_scl_d    <= r_scl_filt;
         r_sda_d    <= r_sda_filt;
         r_scl_rise <= r_scl_filt & ~r_scl_d;
         r_scl_fall <= ~r_scl_filt & r_scl_d;
         r_start    <= w_start_nxt;
         r_rstart   <= w_rstart_nxt;
         r_stop     <= w_stop_nxt;
         r_timeout  <= w_timeout_nxt;
         if ((TIMEOUT_CYC == 0) || (r_state != ST_BUSY) || r_scl_filt || w_to_hit) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TW'(1);
         end
      end
   end

   // Event outputs are single-cycle pulses with no backpressure: the consumer samples every cycle.
   assign scl_filt   = r_scl_filt;
   assign sda_filt   = r_sda_filt;
   assign scl_rise   = r_scl_rise;
   assign scl_fall   = r_scl_fall;
   assign start_det  = r_start;
   assign rstart_det = r_rstart;
   assign stop_det   = r_stop;
   assign timeout    = r_timeout;
   assign bus_busy   = (r_state == ST_BUSY);

endmodule

// File: tb/tb_i2c_bus_cond_det.sv
// Bench for i2c_bus_cond_det: directed bus sequences, expected condition events queued
// with their due cycle and checked by an independent monitor.
module tb_i2c_bus_cond_det;

   localparam int LAT = 4;   // 3 filter edges + 1 registered compare edge
   localparam int TO_LAT = 103;   // 3 filter edges + 100 counted low cycles
   localparam logic [2:0] EV_START  = 3'd1;
   localparam logic [2:0] EV_RSTART = 3'd2;
   localparam logic [2:0] EV_STOP   = 3'd3;
   localparam logic [2:0] EV_TO     = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_in = 1'b1;
   logic sda_in = 1'b1;
   int   cyc = 0;

   logic a_scl_filt, a_sda_filt, a_scl_rise, a_scl_fall;
   logic a_start, a_rstart, a_stop, a_timeout, a_bus_busy;
   logic b_scl_filt, b_sda_filt, b_scl_rise, b_scl_fall;
   logic b_start, b_rstart, b_stop, b_timeout, b_bus_busy;

   logic [34:0] exp_q[$];
   int n_tests = 0;
   int n_fail = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   int b_to_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2c_bus_cond_det #(.FILT_LEN(3), .TIMEOUT_CYC(100)) dut_a (
      .clk(clk), .rst(rst), .scl_sync(scl_in), .sda_sync(sda_in),
      .scl_filt(a_scl_filt), .sda_filt(a_sda_filt), .scl_rise(a_scl_rise), .scl_fall(a_scl_fall),
      .start_det(a_start), .rstart_det(a_rstart), .stop_det(a_stop), .timeout(a_timeout),
      .bus_busy(a_bus_busy)
   );

   i2c_bus_cond_det #(.FILT_LEN(3), .TIMEOUT_CYC(0)) dut_b (
      .clk(clk), .rst(rst), .scl_sync(scl_in), .sda_sync(sda_in),
      .scl_filt(b_scl_filt), .sda_filt(b_sda_filt), .scl_rise(b_scl_rise), .scl_fall(b_scl_fall),
      .start_det(b_start), .rstart_det(b_rstart), .stop_det(b_stop), .timeout(b_timeout),
      .bus_busy(b_bus_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic s, input logic d);
      @(negedge clk);
      scl_in = s;
      sda_in = d;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input int at, input logic [2:0] code);
      logic [31:0] at32;
      at32 = at;
      exp_q.push_back({at32, code});
   endtask

   // Monitor: pops the next expected event whenever dut_a presents a condition pulse.
   initial begin
      int n;
      int e_cnt;
      logic [2:0] code;
      logic [34:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (a_scl_rise) rise_cnt++;
            if (a_scl_fall) fall_cnt++;
            if (b_timeout) b_to_cnt++;
            e_cnt = int'(a_scl_rise) + int'(a_scl_fall);
            if (e_cnt != 0) check("scl_edge_excl", e_cnt, 1);
            n = int'(a_start) + int'(a_rstart) + int'(a_stop) + int'(a_timeout);
            if (n != 0) begin
               check("cond_excl", n, 1);
               code = a_start ? EV_START : a_rstart ? EV_RSTART : a_stop ? EV_STOP : EV_TO;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", code, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("event_code", code, e[2:0]);
                  check("event_cycle", cyc, e[34:3]);
                  check("bus_busy_at_event", a_bus_busy, (code == EV_START || code == EV_RSTART));
               end
            end
         end
      end
   end

   initial begin
      int c, r0, f0;
      logic [34:0] e;
      logic [8:0] pat;
      pat = 9'b101001010;

      // reset and idle
      wait_n(3);
      check("rst_scl_filt", a_scl_filt, 1);
      check("rst_sda_filt", a_sda_filt, 1);
      check("rst_bus_busy", a_bus_busy, 0);
      check("rst_pulses", {a_start, a_rstart, a_stop, a_timeout, a_scl_rise, a_scl_fall}, 0);
      rst = 1'b0;
      wait_n(20);
      check("idle_bus_busy", a_bus_busy, 0);
      check("idle_filts", {a_scl_filt, a_sda_filt}, 2'b11);

      // 2-cycle SDA glitch is rejected
      drive(1'b1, 1'b0);
      wait_n(1);
      drive(1'b1, 1'b1);
      wait_n(6);
      check("glitch_sda_filt", a_sda_filt, 1);
      check("glitch_bus_busy", a_bus_busy, 0);

      // START: sda_filt falls on the 3rd edge, start_det one edge later
      drive(1'b1, 1'b0);
      c = cyc;
      expect_ev(c + LAT, EV_START);
      wait_n(2);
      check("sda_filt_edge2", a_sda_filt, 1);
      wait_n(1);
      check("sda_filt_edge3", a_sda_filt, 0);
      check("busy_before_start", a_bus_busy, 0);
      wait_n(1);
      check("busy_at_start", a_bus_busy, 1);
      wait_n(8);

      // byte + ack: 9 SCL pulses, SDA only moves while SCL is low
      r0 = rise_cnt;
      f0 = fall_cnt;
      for (int i = 8; i >= 0; i--) begin
         drive(1'b0, sda_in);
         wait_n(4);
         drive(1'b0, pat[i]);
         wait_n(4);
         drive(1'b1, pat[i]);
         wait_n(9);
      end
      drive(1'b1, 1'b1);
      c = cyc;
      expect_ev(c + LAT, EV_STOP);
      wait_n(3);
      check("busy_before_stop", a_bus_busy, 1);
      wait_n(5);
      check("byte_rise_count", rise_cnt - r0, 9);
      check("byte_fall_count", fall_cnt - f0, 9);
      check("busy_after_stop", a_bus_busy, 0);

      // repeated START while busy
      drive(1'b1, 1'b0);
      c = cyc;
      expect_ev(c + LAT, EV_START);
      wait_n(10);
      drive(1'b0, 1'b0);
      wait_n(10);
      drive(1'b0, 1'b1);
      wait_n(10);
      drive(1'b1, 1'b1);
      wait_n(10);
      drive(1'b1, 1'b0);
      c = cyc;
      expect_ev(c + LAT, EV_RSTART);
      wait_n(10);
      check("busy_after_rstart", a_bus_busy, 1);

      // SCL held low while busy: timeout on dut_a, never on dut_b
      drive(1'b0, 1'b0);
      c = cyc;
      expect_ev(c + TO_LAT, EV_TO);
      wait_n(TO_LAT - 1);
      check("busy_before_timeout", a_bus_busy, 1);
      wait_n(1);
      check("busy_at_timeout", a_bus_busy, 0);
      check("b_busy_no_timeout", b_bus_busy, 1);
      wait_n(10);
      drive(1'b1, 1'b0);
      wait_n(10);
      drive(1'b1, 1'b1);
      c = cyc;
      expect_ev(c + LAT, EV_STOP);
      wait_n(10);
      check("idle_stop_busy", a_bus_busy, 0);
      check("b_busy_after_stop", b_bus_busy, 0);

      // simultaneous SCL/SDA changes are not conditions
      wait_n(5);
      drive(1'b0, 1'b0);
      wait_n(10);
      drive(1'b1, 1'b1);
      wait_n(10);
      check("simul_bus_busy", a_bus_busy, 0);

      // reset while busy aborts silently
      drive(1'b1, 1'b0);
      c = cyc;
      expect_ev(c + LAT, EV_START);
      wait_n(10);
      check("busy_before_rst", a_bus_busy, 1);
      @(negedge clk);
      rst = 1'b1;
      scl_in = 1'b1;
      sda_in = 1'b1;
      @(negedge clk);
      check("rst_mid_bus_busy", a_bus_busy, 0);
      check("rst_mid_stop", a_stop, 0);
      rst = 1'b0;
      wait_n(15);
      check("post_rst_bus_busy", a_bus_busy, 0);

      // drain and report
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_event: got nothing, expected code %0d at cycle %0d", e[2:0], e[34:3]);
      end
      check("b_timeout_count", b_to_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_cond_det.md
Name: i2c_bus_cond_det

Overview:
- Sits directly downstream of the per-line synchronizers on SCL and SDA.
- Deglitches the already-synchronized lines and produces one-cycle event pulses: SCL rise/fall, START, repeated START, STOP and SCL-low timeout.
- Tracks bus busy/idle state.
- Feeds the I2C slave protocol FSM, which uses its outputs as its sole view of the bus.

Parameters:
- FILT_LEN, 3: consecutive cycles a line must hold a new value before the filtered line follows. Legal range 1..15; 1 means no glitch rejection, only a register stage.
- TIMEOUT_CYC, 65535: clk cycles of continuous filtered SCL low while busy that force a timeout. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- scl_sync  in  1  synchronized SCL, idle high.
- sda_sync  in  1  synchronized SDA, idle high.
- scl_filt  out  1  deglitched SCL.
- sda_filt  out  1  deglitched SDA.
- scl_rise  out  1  one-cycle pulse on scl_filt 0->1.
- scl_fall  out  1  one-cycle pulse on scl_filt 1->0.
- start_det  out  1  one-cycle pulse on START from idle.
- rstart_det  out  1  one-cycle pulse on START while busy.
- stop_det  out  1  one-cycle pulse on STOP.
- timeout  out  1  one-cycle pulse on SCL-low timeout.
- bus_busy  out  1  high between START and STOP/timeout.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset (rst high at a clk edge):
  - scl_filt=1, sda_filt=1; internal previous-value regs=1.
  - Filter counters=0, timeout counter=0.
  - All pulses=0, bus_busy=0, FSM=IDLE.
  - Reset mid-transfer aborts silently: no stop_det or timeout pulse is generated.
- Filter (independent per line, counter width 4):
  - If input == filtered value, counter clears to 0.
  - Otherwise the counter increments. When it reaches FILT_LEN-1 on an edge, that edge loads the filtered value from the input and clears the counter.
  - Net effect: the filtered line updates on the FILT_LEN-th consecutive edge at which the input differs.
  - A glitch shorter than FILT_LEN cycles produces no change.
  - FILT_LEN=1: the filtered value follows the input with 1-cycle latency.
- Edge/condition detect:
  - Registered compare of the filtered lines against their 1-cycle-delayed copies (scl_d, sda_d). Pulses assert the cycle after the filtered line changes, for exactly 1 cycle.
  - START: sda_d=1, sda_filt=0, scl_d=1, scl_filt=1.
  - STOP: sda_d=0, sda_filt=1, scl_d=1, scl_filt=1.
  - SDA and SCL changing on the same cycle is not a START/STOP; only the SCL edge pulse is emitted.
- FSM (states IDLE, BUSY):
  - IDLE + START -> BUSY; start_det=1.
  - IDLE + STOP -> stays IDLE; stop_det still pulses.
  - BUSY + START -> stays BUSY; rstart_det=1, start_det=0.
  - BUSY + STOP -> IDLE; stop_det=1.
  - BUSY + timeout -> IDLE; timeout=1.
  - bus_busy is 1 exactly while in BUSY and rises the same cycle start_det pulses.
- Timeout counter:
  - Width clog2(TIMEOUT_CYC+1).
  - Counts only in BUSY with scl_filt=0, saturating. Clears when scl_filt=1, in IDLE, or after firing.
  - timeout pulses on the edge where the count reaches TIMEOUT_CYC.
  - If STOP and timeout occur on the same edge, STOP wins: stop_det pulses, timeout does not.
  - TIMEOUT_CYC=0: counter held at 0, timeout never asserts.
- Pulse exclusivity:
  - start_det, rstart_det, stop_det and timeout are mutually exclusive.
  - scl_rise and scl_fall are mutually exclusive.

Test Plan:
- Reset, then idle both lines high for 20 cycles -> all pulses 0, bus_busy=0, scl_filt=sda_filt=1.
- FILT_LEN=3; pulse sda_sync low for 2 cycles with scl high -> sda_filt stays 1, no start_det. Then hold it low for 3 cycles -> sda_filt falls on the 3rd edge, start_det=1 one cycle later, bus_busy=1.
- Full byte: START, 9 SCL pulses of 10 high/10 low cycles, then STOP -> exactly 9 scl_rise and 9 scl_fall; stop_det once; bus_busy returns 0 the same cycle stop_det pulses.
- While busy, SDA falls with SCL high -> rstart_det=1, start_det=0, bus_busy stays 1.
- TIMEOUT_CYC=100; START, then hold SCL low 100 cycles -> timeout pulses exactly once, bus_busy=0. Rerun with TIMEOUT_CYC=0 -> no timeout ever.
- Toggle SCL and SDA on the same cycle with SCL high before; separately assert rst while BUSY -> no start/stop pulse in the first case; in the second, bus_busy=0 next cycle with no stop_det.
